// File: rtl/int_arbiter.sv
// int_arbiter: edge-detecting, fixed-priority, non-nesting vectored interrupt
// arbiter with a request/acknowledge/done handshake toward the core.
module int_arbiter #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_00C0,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  done,
  input  logic [3:0]  mask,
  input  logic        int_en,
  input  logic        int_ack,
  input  logic        int_done,
  output logic        int_req,
  output logic [31:0] int_addr,
  output logic [1:0]  int_id,
  output logic        in_service,
  output logic [3:0]  pending,
  output logic [3:0]  ovr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  done_q;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  ovr_q, ovr_d;
  logic        int_req_q, int_req_d;
  logic        in_service_q, in_service_d;
  logic [1:0]  int_id_q, int_id_d;

  logic [3:0]  done_edge;
  logic [3:0]  clr;
  logic [3:0]  eligible;
  logic [1:0]  prio_id;

  // Event detection, pending/overrun bookkeeping and eligibility.
  always_comb begin
    done_edge = done & ~done_q;
    clr       = 4'b0000;
    if (state_q == REQ && int_ack) begin
      clr[int_id_q] = 1'b1;
    end
    // A new event wins over a clear landing in the same cycle.
    pending_d = done_edge | (pending_q & ~clr);
    // Events coalesce into one pending bit; the overrun flag records the loss.
    ovr_d     = ovr_q | (done_edge & pending_q & ~clr);
    eligible  = int_en ? (pending_q & mask) : 4'b0000;
  end

  // Fixed-priority encoder: lowest index wins.
  always_comb begin
    prio_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) prio_id = 2'(i);
    end
  end

  // Handshake FSM next-state and registered-output values.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    int_req_d    = int_req_q;
    in_service_d = in_service_q;
    int_id_d     = int_id_q;
    unique case (state_q)
      IDLE: begin
        if (eligible != 4'b0000) begin
          int_id_d  = prio_id;
          int_req_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        // int_id stays frozen here; an ack beats a simultaneous withdraw.
        if (int_ack) begin
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
          state_d      = SERVICE;
        end else if (!int_en || !mask[int_id_q]) begin
          int_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      SERVICE: begin
        if (int_done) begin
          in_service_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        int_req_d    = 1'b0;
        in_service_d = 1'b0;
      end
    endcase
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q      <= IDLE;
      done_q       <= 4'b0000;
      pending_q    <= 4'b0000;
      ovr_q        <= 4'b0000;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
      int_id_q     <= 2'd0;
    end else begin
      state_q      <= state_d;
      done_q       <= done;
      pending_q    <= pending_d;
      ovr_q        <= ovr_d;
      int_req_q    <= int_req_d;
      in_service_q <= in_service_d;
      int_id_q     <= int_id_d;
    end
  end

  assign int_req    = int_req_q;
  assign in_service = in_service_q;
  assign int_id     = int_id_q;
  assign pending    = pending_q;
  assign ovr        = ovr_q;
  // Derived only from the registered id, so it is stable for the whole request.
  assign int_addr   = VEC_BASE + 32'(int_id_q) * VEC_STRIDE;

endmodule

// File: tb/tb_int_arbiter.sv
// Self-checking bench for int_arbiter: expectations are queued alongside the
// stimulus and compared after the edge (or reset) that should produce them.
module tb_int_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  done;
  logic [3:0]  mask;
  logic        int_en;
  logic        int_ack;
  logic        int_done;
  logic        int_req;
  logic [31:0] int_addr;
  logic [1:0]  int_id;
  logic        in_service;
  logic [3:0]  pending;
  logic [3:0]  ovr;

  int n_compared;
  int n_mismatched;

  typedef enum int { S_REQ, S_ID, S_ADDR, S_SVC, S_PEND, S_OVR } sel_e;
  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;
  exp_t sb_q[$];

  int_arbiter dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .done       (done),
    .mask       (mask),
    .int_en     (int_en),
    .int_ack    (int_ack),
    .int_done   (int_done),
    .int_req    (int_req),
    .int_addr   (int_addr),
    .int_id     (int_id),
    .in_service (in_service),
    .pending    (pending),
    .ovr        (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] observe(input sel_e s);
    case (s)
      S_REQ:   return {31'd0, int_req};
      S_ID:    return {30'd0, int_id};
      S_ADDR:  return int_addr;
      S_SVC:   return {31'd0, in_service};
      S_PEND:  return {28'd0, pending};
      default: return {28'd0, ovr};
    endcase
  endfunction

  task automatic expect_val(input string tag, input sel_e sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.tag, observe(e.sel), e.exp);
    end
  endtask

  // One rising edge, then compare everything queued for it.
  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset_n  = 1'b0;
    done     = 4'b0000;
    mask     = 4'hF;
    int_en   = 1'b1;
    int_ack  = 1'b0;
    int_done = 1'b0;

    // Reset values.
    #12;
    expect_val("rst_req",  S_REQ,  0);
    expect_val("rst_id",   S_ID,   0);
    expect_val("rst_addr", S_ADDR, 32'h0000_00C0);
    expect_val("rst_svc",  S_SVC,  0);
    expect_val("rst_pend", S_PEND, 0);
    expect_val("rst_ovr",  S_OVR,  0);
    drain();
    reset_n = 1'b1;
    tick();

    // Basic event on source 2.
    done = 4'b0100;
    expect_val("t1_pend", S_PEND, 4'b0100);
    expect_val("t1_noreq", S_REQ, 0);
    tick();
    expect_val("t1_req",  S_REQ,  1);
    expect_val("t1_id",   S_ID,   2);
    expect_val("t1_addr", S_ADDR, 32'h0000_00E0);
    tick();
    int_ack = 1'b1;
    expect_val("t1_ack_pend", S_PEND, 0);
    expect_val("t1_ack_svc",  S_SVC,  1);
    expect_val("t1_ack_req",  S_REQ,  0);
    tick();
    int_ack = 1'b0;
    int_done = 1'b1;
    expect_val("t1_done_svc", S_SVC, 0);
    tick();
    int_done = 1'b0;
    done = 4'b0000;
    tick();

    // Priority and freeze.
    done = 4'b1000;
    expect_val("t2_pend3", S_PEND, 4'b1000);
    tick();
    expect_val("t2_req", S_REQ, 1);
    expect_val("t2_id3", S_ID,  3);
    tick();
    done = 4'b1001;
    expect_val("t2_frz_id",   S_ID,   3);
    expect_val("t2_frz_addr", S_ADDR, 32'h0000_00F0);
    expect_val("t2_frz_req",  S_REQ,  1);
    expect_val("t2_frz_pend", S_PEND, 4'b1001);
    tick();
    int_ack = 1'b1;
    expect_val("t2_ack_svc",  S_SVC,  1);
    expect_val("t2_ack_pend", S_PEND, 4'b0001);
    tick();
    int_ack = 1'b0;
    done = 4'b0000;
    int_done = 1'b1;
    expect_val("t2_done_svc", S_SVC, 0);
    expect_val("t2_done_req", S_REQ, 0);
    tick();
    int_done = 1'b0;
    expect_val("t2_next_req",  S_REQ,  1);
    expect_val("t2_next_id",   S_ID,   0);
    expect_val("t2_next_addr", S_ADDR, 32'h0000_00C0);
    tick();
    int_ack = 1'b1;
    expect_val("t2_ack0_pend", S_PEND, 0);
    tick();
    int_ack = 1'b0;
    int_done = 1'b1;
    tick();
    int_done = 1'b0;

    // Masking and withdraw.
    mask = 4'b1101;
    done = 4'b0010;
    expect_val("t3_pend1", S_PEND, 4'b0010);
    tick();
    expect_val("t3_masked_a", S_REQ, 0);
    tick();
    expect_val("t3_masked_b", S_REQ, 0);
    tick();
    mask = 4'hF;
    expect_val("t3_unmask_req", S_REQ, 1);
    expect_val("t3_unmask_id",  S_ID,  1);
    tick();
    int_en = 1'b0;
    expect_val("t3_wd_req",  S_REQ,  0);
    expect_val("t3_wd_pend", S_PEND, 4'b0010);
    tick();
    expect_val("t3_dis_req", S_REQ, 0);
    tick();
    int_en = 1'b1;
    expect_val("t3_rereq", S_REQ, 1);
    expect_val("t3_reid",  S_ID,  1);
    tick();

    // Collision: new event on the source being acknowledged.
    done = 4'b0000;
    expect_val("t4_hold_req", S_REQ, 1);
    tick();
    done = 4'b0010;
    int_ack = 1'b1;
    expect_val("t4_col_pend", S_PEND, 4'b0010);
    expect_val("t4_col_ovr",  S_OVR,  0);
    expect_val("t4_col_svc",  S_SVC,  1);
    tick();
    int_ack = 1'b0;
    // Overrun: second event while still pending.
    done = 4'b0000;
    tick();
    done = 4'b0010;
    expect_val("t4_ovr",      S_OVR,  4'b0010);
    expect_val("t4_ovr_pend", S_PEND, 4'b0010);
    tick();

    // Non-nesting and spurious handshakes in SERVICE.
    done = 4'b0011;
    expect_val("t5_svc_pend", S_PEND, 4'b0011);
    expect_val("t5_svc_noreq", S_REQ, 0);
    tick();
    int_ack = 1'b1;
    expect_val("t5_spur_svc",  S_SVC,  1);
    expect_val("t5_spur_req",  S_REQ,  0);
    expect_val("t5_spur_pend", S_PEND, 4'b0011);
    tick();
    int_ack = 1'b0;
    int_done = 1'b1;
    expect_val("t5_done_svc", S_SVC, 0);
    expect_val("t5_done_req", S_REQ, 0);
    tick();
    int_done = 1'b0;
    expect_val("t5_req2", S_REQ, 1);
    expect_val("t5_id2",  S_ID,  0);
    tick();
    int_ack = 1'b1;
    expect_val("t5_ack_svc",  S_SVC,  1);
    expect_val("t5_ack_pend", S_PEND, 4'b0010);
    tick();
    int_ack = 1'b0;

    // Asynchronous reset mid-SERVICE, between edges.
    #2;
    done = 4'b0100;
    reset_n = 1'b0;
    #1;
    expect_val("t6_svc",  S_SVC,  0);
    expect_val("t6_req",  S_REQ,  0);
    expect_val("t6_pend", S_PEND, 0);
    expect_val("t6_ovr",  S_OVR,  0);
    expect_val("t6_id",   S_ID,   0);
    drain();
    reset_n = 1'b1;
    // done held high across reset counts as an event at the first edge.
    expect_val("t6_first_pend", S_PEND, 4'b0100);
    expect_val("t6_first_noreq", S_REQ, 0);
    tick();
    expect_val("t6_first_req", S_REQ, 1);
    expect_val("t6_first_id",  S_ID,  2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
